// File: rtl/stream_sink_checker.sv
// FIFO-style read-side sink: counts accepted beats, folds data into a 32-bit signature,
// flags done / timeout / surplus. Define SINK_THROTTLE_EN for LFSR-driven read throttling.
module stream_sink_checker #(
  parameter int unsigned DATA_WIDTH     = 512,
  parameter int unsigned EXP_BEATS      = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned CNT_WIDTH      = 32,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  empty_n,
  output logic                  read,
  output logic [CNT_WIDTH-1:0]  beat_cnt,
  output logic [31:0]           checksum,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic                  err
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE, ST_TIMEOUT} state_e;

  localparam int unsigned          NSLICE  = DATA_WIDTH / 32;
  localparam logic [CNT_WIDTH-1:0] EXP_CNT = CNT_WIDTH'(EXP_BEATS);
  localparam logic [CNT_WIDTH-1:0] TO_CNT  = CNT_WIDTH'(TIMEOUT_CYCLES);

  if (DATA_WIDTH == 0 || DATA_WIDTH % 32 != 0) begin : g_bad_width
    $error("stream_sink_checker: DATA_WIDTH must be a nonzero multiple of 32");
  end
  if (EXP_BEATS < 1 || TIMEOUT_CYCLES < 1 || LFSR_SEED == 16'h0) begin : g_bad_cfg
    $error("stream_sink_checker: EXP_BEATS, TIMEOUT_CYCLES and LFSR_SEED must be nonzero");
  end

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic [CNT_WIDTH-1:0] idle_cnt_q, idle_cnt_d;
  logic [31:0]          checksum_q, checksum_d;
  logic                 err_q, err_d;
  logic [31:0]          fold;
  logic                 allow;
  logic                 xfer;
  logic                 launch;

  // start is honoured everywhere except RUN
  assign launch = start && (state_q != ST_RUN);

`ifdef SINK_THROTTLE_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (launch) begin
      lfsr_d = LFSR_SEED;
    end else if (state_q == ST_RUN) begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign allow = lfsr_q[0] | lfsr_q[1];
`else
  assign allow = 1'b1;
`endif

  always_comb begin
    fold = '0;
    for (int unsigned i = 0; i < NSLICE; i++) fold = fold ^ din[i*32 +: 32];
  end

  assign xfer = (state_q == ST_RUN) && allow && empty_n;

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    idle_cnt_d = idle_cnt_q;
    checksum_d = checksum_q;
    err_d      = err_q;
    unique case (state_q)
      ST_RUN: begin
        if (xfer) begin
          beat_cnt_d = (beat_cnt_q == '1) ? beat_cnt_q : beat_cnt_q + CNT_WIDTH'(1);
          checksum_d = {checksum_q[30:0], checksum_q[31]} ^ fold;
          idle_cnt_d = '0;
          if (beat_cnt_d == EXP_CNT) state_d = ST_DONE;
        end else begin
          idle_cnt_d = idle_cnt_q + CNT_WIDTH'(1);
          if (idle_cnt_d == TO_CNT) state_d = ST_TIMEOUT;
        end
      end
      ST_DONE:    if (empty_n) err_d = 1'b1;
      default:    ;
    endcase
    // a restart overrides the per-state updates above, including a same-cycle surplus flag
    if (launch) begin
      state_d    = ST_RUN;
      beat_cnt_d = '0;
      idle_cnt_d = '0;
      checksum_d = '0;
      err_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
      idle_cnt_q <= '0;
      checksum_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      checksum_q <= checksum_d;
      err_q      <= err_d;
    end
  end

  assign read     = (state_q == ST_RUN) && allow;
  assign busy     = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);
  assign timeout  = (state_q == ST_TIMEOUT);
  assign err      = err_q;
  assign beat_cnt = beat_cnt_q;
  assign checksum = checksum_q;

endmodule

// File: tb/tb_stream_sink_checker.sv
// Randomized self-checking bench for stream_sink_checker; expected signatures come from
// a queue-based reference over the words offered to the sink.
module tb_stream_sink_checker;

  localparam int unsigned DW  = 64;
  localparam int unsigned EXP = 4;
  localparam int unsigned TO  = 8;
  localparam int unsigned CW  = 32;

  logic          clk;
  logic          reset;
  logic          start;
  logic [DW-1:0] din;
  logic          empty_n;
  logic          read;
  logic [CW-1:0] beat_cnt;
  logic [31:0]   checksum;
  logic          busy;
  logic          done;
  logic          timeout;
  logic          err;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] words[$];

  stream_sink_checker #(
    .DATA_WIDTH(DW),
    .EXP_BEATS(EXP),
    .TIMEOUT_CYCLES(TO),
    .CNT_WIDTH(CW),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .din(din),
    .empty_n(empty_n),
    .read(read),
    .beat_cnt(beat_cnt),
    .checksum(checksum),
    .busy(busy),
    .done(done),
    .timeout(timeout),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no_finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Signature of the first k offered words: rotate-left-by-one then XOR the 32-bit slices.
  function automatic logic [31:0] ref_sig(input int k);
    logic [31:0] s;
    s = 32'h0;
    for (int i = 0; i < k; i++) begin
      s = {s[30:0], s[31]};
      for (int j = 0; j < int'(DW / 32); j++) s = s ^ 32'(words[i] >> (32 * j));
    end
    return s;
  endfunction

  task automatic fill_random(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back({$urandom, $urandom});
  endtask

  task automatic do_start(input string tag);
    start   = 1'b1;
    empty_n = 1'b0;
    step();
    start = 1'b0;
    check_val({tag, "_busy"}, {busy, done, timeout, err}, 4'b1000);
    check_val({tag, "_cnt0"}, beat_cnt, 0);
    check_val({tag, "_sum0"}, checksum, 0);
  endtask

  // Offer words[0..n-1] with random gaps; optionally pulse start mid-run at beat index poke_at.
  task automatic feed(input int n, input int max_gap, input int poke_at,
                      output int cycles, output int idles);
    int  sent;
    int  gap;
    bit  poked;
    bit  xfer;
    sent   = 0;
    cycles = 0;
    idles  = 0;
    poked  = 1'b0;
    gap    = $urandom_range(0, max_gap);
    while (sent < n && cycles < 300) begin
      if (gap > 0) begin
        empty_n = 1'b0;
        din     = {$urandom, $urandom};
        gap--;
        idles++;
      end else begin
        empty_n = 1'b1;
        din     = words[sent];
      end
      if (sent == poke_at && !poked) begin
        start = 1'b1;
        poked = 1'b1;
      end
      xfer = read && empty_n;
      step();
      start = 1'b0;
      cycles++;
      if (xfer) begin
        sent++;
        gap = $urandom_range(0, max_gap);
      end
      check_val("beat_track", beat_cnt, sent);
      check_val("sum_track", checksum, ref_sig(sent));
    end
    empty_n = 1'b0;
    check_val("feed_sent", sent, n);
  endtask

  task automatic expect_done(input string tag, input int cycles, input int idles);
    check_val({tag, "_flags"}, {read, busy, done, timeout, err}, 5'b00100);
    check_val({tag, "_cnt"}, beat_cnt, EXP);
    check_val({tag, "_sum"}, checksum, ref_sig(EXP));
`ifdef SINK_THROTTLE_EN
    check_val({tag, "_cyc_min"}, cycles >= int'(EXP) + idles, 1);
`else
    check_val({tag, "_cycles"}, cycles, int'(EXP) + idles);
`endif
  endtask

  task automatic wait_timeout(input string tag, input int exp_beats);
    int k;
    k = 0;
    empty_n = 1'b0;
    while (!timeout && k < 40) begin
      step();
      k++;
    end
    check_val({tag, "_latency"}, k, TO);
    check_val({tag, "_flags"}, {read, busy, done, timeout, err}, 5'b00010);
    check_val({tag, "_cnt"}, beat_cnt, exp_beats);
  endtask

  initial begin
    int cyc;
    int idl;
    reset   = 1'b1;
    start   = 1'b0;
    empty_n = 1'b1;
    din     = {$urandom, $urandom};

    // reset held 3 cycles with data present
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("rst_flags", {read, busy, done, timeout, err}, 5'b00000);
      check_val("rst_cnt", beat_cnt, 0);
      check_val("rst_sum", checksum, 0);
    end
    reset = 1'b0;
    step();
    check_val("idle_flags", {read, busy, done, timeout, err}, 5'b00000);

    // nominal: 1,2,3,4 back-to-back
    words.delete();
    for (int i = 1; i <= 4; i++) words.push_back(64'(i));
    do_start("nom_start");
    check_val("nom_read_first", read | 1'b0, 1'b1 & busy);
    feed(4, 0, -1, cyc, idl);
    expect_done("nom", cyc, idl);
    check_val("nom_sum_const", checksum, 32'h2);

    // surplus data after done
    empty_n = 1'b1;
    din     = {$urandom, $urandom};
    step();
    check_val("surplus_err", {err, read, done}, 3'b101);
    step();
    check_val("surplus_sticky", {err, read}, 2'b10);
    do_start("surplus_clear");

    // pure timeout from start
    wait_timeout("to_empty", 0);
    empty_n = 1'b1;
    step();
    check_val("to_no_err", {err, read, timeout}, 3'b001);

    // partial run then stall
    fill_random(2);
    do_start("to_part_start");
    feed(2, 0, -1, cyc, idl);
    wait_timeout("to_part", 2);

    // reset mid-run
    fill_random(EXP);
    do_start("mid_start");
    feed(2, 1, -1, cyc, idl);
    reset   = 1'b1;
    empty_n = 1'b1;
    step();
    reset   = 1'b0;
    empty_n = 1'b0;
    check_val("mid_rst_flags", {read, busy, done, timeout, err}, 5'b00000);
    check_val("mid_rst_cnt", beat_cnt, 0);
    check_val("mid_rst_sum", checksum, 0);
    step();
    check_val("mid_idle", {read, busy}, 2'b00);
    do_start("mid_restart");
    feed(EXP, 0, -1, cyc, idl);
    expect_done("mid_done", cyc, idl);

    // randomized runs, some with a start pulse mid-run that must be ignored
    for (int r = 0; r < 16; r++) begin
      fill_random(EXP);
      do_start("rnd_start");
      feed(EXP, 5, (r % 3 == 0) ? int'($urandom_range(0, EXP - 1)) : -1, cyc, idl);
      expect_done("rnd", cyc, idl);
      if (r % 4 == 1) begin
        empty_n = 1'b1;
        step();
        empty_n = 1'b0;
        check_val("rnd_surplus", {err, done}, 2'b11);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
